// File: rtl/ring_contactor_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ring_contactor_sequencer
// Purpose  : Changes the eight ring contactors (bit 0 = A .. bit 7 = H) one at
//            a time toward the requested state. Opens go before closes, and a
//            close is refused while it would complete a forbidden ring loop.
//            After each command the block waits for matching feedback, with a
//            timeout, then settles. Any stuck or unexpected contactor latches a
//            fault that opens everything until it is acknowledged.
// Ports    : i_Clk        clock, rising edge
//            i_Rst        synchronous active-high reset
//            i_Req[7:0]   requested state, 1 = closed
//            i_Fb[7:0]    auxiliary feedback, 1 = closed (already synchronised)
//            i_FaultClr   single-cycle fault acknowledge
//            o_Cmd[7:0]   close commands to the drivers
//            o_Busy       high whenever not idle
//            o_Blocked    pending closes refused by the interlock
//            o_Fault      latched fault
//            o_FaultIdx   contactor that caused the fault
// Revision : 1.0  initial release
// ============================================================================
module ring_contactor_sequencer #(
  parameter int P_TIMEOUT = 1000,
  parameter int P_SETTLE  = 4
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [7:0] i_Req,
  input  logic [7:0] i_Fb,
  input  logic       i_FaultClr,
  output logic [7:0] o_Cmd,
  output logic       o_Busy,
  output logic [7:0] o_Blocked,
  output logic       o_Fault,
  output logic [2:0] o_FaultIdx
);

  // One counter serves both the feedback timeout and the settle delay.
  localparam int TMR_W = $clog2(P_TIMEOUT + 1);
  localparam int SET_W = $clog2(P_SETTLE + 1);
  localparam int CNT_W = (TMR_W > SET_W) ? TMR_W : SET_W;
  localparam logic [CNT_W-1:0] C_TMO_LAST = CNT_W'(P_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_SET_LAST = CNT_W'(P_SETTLE - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  // Forbidden loop sets, seven masks packed side by side.
  localparam int N_FORBID = 7;
  localparam logic [8*N_FORBID-1:0] C_FORBID =
    {8'hE6, 8'hDA, 8'hB9, 8'hB1, 8'hC6, 8'hAD, 8'hC1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_FB = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       blocked_q, blocked_d;
  logic             fault_q, fault_d;
  logic [2:0]       fault_idx_q, fault_idx_d;

  logic [7:0] legal;
  logic [7:0] pend;
  logic [7:0] mism;
  logic [3:0] open_pick;
  logic [3:0] close_pick;
  logic [3:0] pick;

  // Round-robin search starting one past the pointer; returns {found, index}.
  function automatic logic [3:0] rr_pick(input logic [7:0] cand, input logic [2:0] ptr);
    logic       found;
    logic [2:0] idx;
    found = 1'b0;
    idx   = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      logic [2:0] j;
      j = ptr + 3'(i);
      if (!found && cand[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  // A close of k is legal if, with k added to everything already commanded or
  // reporting closed, no forbidden set is fully closed.
  always_comb begin
    logic [7:0] base;
    logic [7:0] m;
    legal = '1;
    base  = '0;
    m     = '0;
    for (int k = 0; k < 8; k++) begin
      base = cmd_q | i_Fb | (8'h01 << k);
      for (int f = 0; f < N_FORBID; f++) begin
        m = C_FORBID[f*8 +: 8];
        if ((base & m) == m) legal[k] = 1'b0;
      end
    end
  end

  assign pend       = i_Req ^ cmd_q;
  assign mism       = i_Fb ^ cmd_q;
  assign open_pick  = rr_pick(pend & cmd_q, ptr_q);
  assign close_pick = rr_pick(pend & ~cmd_q & legal, ptr_q);
  // Any pending open wins over every close, regardless of pointer position.
  assign pick       = open_pick[3] ? open_pick : close_pick;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    blocked_d   = blocked_q;
    fault_d     = fault_q;
    fault_idx_d = fault_idx_q;

    case (state_q)
      ST_IDLE: begin
        blocked_d = pend & ~cmd_q & ~legal;
        if (mism != 8'h00) begin
          state_d     = ST_FAULT;
          fault_d     = 1'b1;
          fault_idx_d = lowest_set(mism);
        end else if (pick[3]) begin
          cmd_d   = cmd_q ^ (8'h01 << pick[2:0]);
          ptr_d   = pick[2:0];
          cnt_d   = '0;
          state_d = ST_WAIT_FB;
        end
      end

      // ptr_q holds the contactor being changed.
      ST_WAIT_FB: begin
        if (i_Fb[ptr_q] == cmd_q[ptr_q]) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end else if (cnt_q == C_TMO_LAST) begin
          state_d     = ST_FAULT;
          fault_d     = 1'b1;
          fault_idx_d = ptr_q;
        end else if (cnt_q != C_CNT_MAX) begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end

      ST_SETTLE: begin
        if (mism != 8'h00) begin
          state_d     = ST_FAULT;
          fault_d     = 1'b1;
          fault_idx_d = lowest_set(mism);
        end else if (cnt_q >= C_SET_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end

      ST_FAULT: begin
        // Commands drop one cycle after entry since cmd_q changes on this edge.
        cmd_d     = 8'h00;
        blocked_d = 8'h00;
        fault_d   = 1'b1;
        if (i_FaultClr && (i_Fb == 8'h00)) begin
          state_d = ST_IDLE;
          fault_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= 8'h00;
      ptr_q       <= 3'd7;
      cnt_q       <= '0;
      blocked_q   <= 8'h00;
      fault_q     <= 1'b0;
      fault_idx_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      blocked_q   <= blocked_d;
      fault_q     <= fault_d;
      fault_idx_q <= fault_idx_d;
    end
  end

  assign o_Cmd      = cmd_q;
  assign o_Busy     = (state_q != ST_IDLE);
  assign o_Blocked  = blocked_q;
  assign o_Fault    = fault_q;
  assign o_FaultIdx = fault_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_ring_contactor_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ring_contactor_sequencer
// Purpose  : Scoreboard bench. Each request is run through a transaction-level
//            model that lists the command values the sequencer should step
//            through and the cycle of each step; a monitor compares every
//            observed o_Cmd change against that list. Directed checks cover
//            reset, blocking, timeout, unexpected feedback and mid-run reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_ring_contactor_sequencer;

  localparam int P_TIMEOUT = 1000;
  localparam int P_SETTLE  = 4;
  localparam int FB_DLY    = 3;
  // Cycles between consecutive command changes when feedback lags by FB_DLY:
  // match sampled FB_DLY+1 edges after the change, settle, one idle decision.
  localparam int GAP       = FB_DLY + 1 + P_SETTLE + 1;
  localparam logic [7:0] FORB [7] = '{8'hC1, 8'hAD, 8'hC6, 8'hB1, 8'hB9, 8'hDA, 8'hE6};

  logic       clk = 1'b0;
  logic       i_Rst = 1'b1;
  logic [7:0] i_Req = 8'h00;
  logic [7:0] i_Fb;
  logic       i_FaultClr = 1'b0;
  logic [7:0] o_Cmd;
  logic       o_Busy;
  logic [7:0] o_Blocked;
  logic       o_Fault;
  logic [2:0] o_FaultIdx;

  always #5 clk = ~clk;

  ring_contactor_sequencer #(.P_TIMEOUT(P_TIMEOUT), .P_SETTLE(P_SETTLE)) dut (
    .i_Clk(clk), .i_Rst(i_Rst), .i_Req(i_Req), .i_Fb(i_Fb), .i_FaultClr(i_FaultClr),
    .o_Cmd(o_Cmd), .o_Busy(o_Busy), .o_Blocked(o_Blocked), .o_Fault(o_Fault),
    .o_FaultIdx(o_FaultIdx)
  );

  // Contactor plant: feedback follows the command FB_DLY cycles later unless forced.
  logic [FB_DLY*8-1:0] fb_pipe = '0;
  logic       fb_force = 1'b0;
  logic [7:0] fb_force_val = 8'h00;
  always @(posedge clk) begin
    if (i_Rst) fb_pipe <= '0;
    else       fb_pipe <= {fb_pipe[(FB_DLY-1)*8-1:0], o_Cmd};
  end
  assign i_Fb = fb_force ? fb_force_val : fb_pipe[FB_DLY*8-1 -: 8];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] cmd; int t; } exp_t;
  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: what the contactor commands and rotating pointer should be.
  logic [7:0] m_cmd = 8'h00;
  int         m_ptr = 7;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit m_legal(input logic [7:0] cmd, input int k);
    logic [7:0] base;
    base = cmd | (8'h01 << k);
    foreach (FORB[f]) if ((base & FORB[f]) == FORB[f]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int m_rr(input logic [7:0] cand, input int ptr);
    for (int i = 1; i <= 8; i++) begin
      int j;
      j = (ptr + i) % 8;
      if (cand[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [7:0] m_blocked(input logic [7:0] req);
    logic [7:0] b;
    b = 8'h00;
    for (int k = 0; k < 8; k++)
      if (req[k] && !m_cmd[k] && !m_legal(m_cmd, k)) b[k] = 1'b1;
    return b;
  endfunction

  // Walk the request to completion: one contactor per step, opens first.
  task automatic run_model(input logic [7:0] req, input int t0);
    int t;
    int k;
    logic [7:0] closes;
    t = t0;
    forever begin
      k = m_rr((req ^ m_cmd) & m_cmd, m_ptr);
      if (k < 0) begin
        closes = 8'h00;
        for (int b = 0; b < 8; b++)
          if (req[b] && !m_cmd[b] && m_legal(m_cmd, b)) closes[b] = 1'b1;
        k = m_rr(closes, m_ptr);
      end
      if (k < 0) break;
      m_cmd[k] = ~m_cmd[k];
      m_ptr = k;
      exp_q.push_back('{cmd: m_cmd, t: t});
      t += GAP;
    end
  endtask

  // Monitor: every command change must be the next expected one, on time.
  bit mon_en = 1'b0;
  logic [7:0] prev_cmd = 8'h00;
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && (o_Cmd != prev_cmd)) begin
      if (exp_q.size() == 0) begin
        check("cmd_unexpected_change", int'(o_Cmd), int'(prev_cmd));
      end else begin
        e = exp_q.pop_front();
        check("cmd_value", int'(o_Cmd), int'(e.cmd));
        check("cmd_cycle", cyc, e.t);
      end
    end
    prev_cmd = o_Cmd;
  end

  task automatic apply_req(input logic [7:0] v);
    @(negedge clk);
    i_Req = v;
    run_model(v, cyc + 1);
  endtask

  task automatic wait_quiet(input string nm);
    int b;
    b = 0;
    while ((exp_q.size() != 0 || o_Busy) && b < 3000) begin
      @(negedge clk);
      b++;
    end
    if (b >= 3000) begin
      check({nm, "_quiet_timeout"}, exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
    check({nm, "_cmd"}, int'(o_Cmd), int'(m_cmd));
    check({nm, "_blocked"}, int'(o_Blocked), int'(m_blocked(i_Req)));
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_Rst = 1'b1;
    i_Req = 8'h00;
    if (m_cmd != 8'h00) exp_q.push_back('{cmd: 8'h00, t: cyc + 1});
    @(negedge clk);
    i_Rst = 1'b0;
    m_cmd = 8'h00;
    m_ptr = 7;
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_cmd"}, int'(o_Cmd), 0);
    check({nm, "_busy"}, int'(o_Busy), 0);
    check({nm, "_blocked"}, int'(o_Blocked), 0);
    check({nm, "_fault"}, int'(o_Fault), 0);
    check({nm, "_fault_idx"}, int'(o_FaultIdx), 0);
  endtask

  task automatic random_rounds(input int n);
    for (int r = 0; r < n; r++) begin
      apply_req(8'($urandom_range(0, 255)));
      wait_quiet("random");
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    int t_cmd;
    int b;

    repeat (3) @(negedge clk);
    i_Rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    mon_en = 1'b1;

    // Single close with lagging feedback: busy through wait and settle.
    apply_req(8'h01);
    busy_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_Busy) busy_cnt++;
    end
    check("busy_cycles", busy_cnt, FB_DLY + 1 + P_SETTLE);
    wait_quiet("close_a");

    // H would complete {A,G,H}: blocked until G opens.
    apply_req(8'h41);
    wait_quiet("close_g");
    apply_req(8'hC1);
    wait_quiet("block_h");
    check("block_h_value", int'(o_Blocked), 8'h80);
    apply_req(8'h81);
    wait_quiet("swap_g_h");
    check("swap_g_h_value", int'(o_Cmd), 8'h81);

    // Three closes at once, then opens before the close.
    apply_req(8'h00);
    wait_quiet("open_all");
    apply_req(8'h07);
    wait_quiet("close_abc");
    apply_req(8'h03);
    wait_quiet("open_c");
    apply_req(8'h04);
    wait_quiet("open_ab_close_c");

    random_rounds(25);

    // Timeout: B never reports closed.
    do_reset();
    fb_force = 1'b1;
    fb_force_val = 8'h00;
    apply_req(8'h02);
    t_cmd = cyc + 1;
    b = 0;
    while (!o_Fault && b < P_TIMEOUT + 100) begin
      @(negedge clk);
      b++;
    end
    check("timeout_fault_seen", int'(o_Fault), 1);
    check("timeout_latency", cyc - t_cmd, P_TIMEOUT);
    check("timeout_fault_idx", int'(o_FaultIdx), 1);
    check("timeout_cmd_at_entry", int'(o_Cmd), 8'h02);
    exp_q.push_back('{cmd: 8'h00, t: cyc + 1});
    m_cmd = 8'h00;
    @(negedge clk);
    check("timeout_cmd_dropped", int'(o_Cmd), 0);
    check("timeout_blocked_clr", int'(o_Blocked), 0);
    repeat (6) @(negedge clk);
    check("timeout_fault_held", int'(o_Fault), 1);
    fb_force = 1'b0;
    i_FaultClr = 1'b1;
    run_model(8'h02, cyc + 2);
    @(negedge clk);
    i_FaultClr = 1'b0;
    check("fault_clear", int'(o_Fault), 0);
    wait_quiet("retry_b");

    // Unexpected feedback on E while idle.
    apply_req(8'h00);
    wait_quiet("open_b");
    @(negedge clk);
    fb_force = 1'b1;
    fb_force_val = 8'h10;
    @(negedge clk);
    check("stray_fault", int'(o_Fault), 1);
    check("stray_fault_idx", int'(o_FaultIdx), 4);
    @(negedge clk);
    fb_force = 1'b0;
    i_FaultClr = 1'b1;
    @(negedge clk);
    i_FaultClr = 1'b0;
    check("stray_clear", int'(o_Fault), 0);

    // Reset during a pending change.
    apply_req(8'h01);
    repeat (2) @(negedge clk);
    check("midrun_busy", int'(o_Busy), 1);
    i_Rst = 1'b1;
    i_Req = 8'h00;
    exp_q.push_back('{cmd: 8'h00, t: cyc + 1});
    @(negedge clk);
    check_reset_outputs("midrun_reset");
    i_Rst = 1'b0;
    m_cmd = 8'h00;
    m_ptr = 7;
    // Pointer back at 7 means A is served before B.
    apply_req(8'h03);
    wait_quiet("after_reset");

    random_rounds(20);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
